// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//   Program-counter register stage feeding an N-bit incrementer (incN) and
//   loading its result back on every advancing cycle. It also handles branch
//   redirects with a one-cycle flush bubble, stall hold, and a halt/resume
//   state machine. All outputs come straight from flops.
//
// Ports
//   clk        in   single clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   stall      in   hold the PC this cycle
//   br_taken   in   redirect request; PC becomes br_target
//   br_target  in   [N-1:0] branch destination
//   halt       in   enter HALTED
//   resume     in   leave HALTED (ignored while halt is also high)
//   pc         out  [N-1:0] registered current PC
//   pc_valid   out  pc is a valid fetch address this cycle
//   halted     out  high while in HALTED
//   wrap       out  one-cycle pulse after an advance from all-ones to zero
// -----------------------------------------------------------------------------

// incN: N-bit modulo incrementer. The carry out of the top bit is dropped;
// wrap detection is done in the sequencer by looking at the PC itself.
//   a_i  in   [N-1:0] operand
//   y_o  out  [N-1:0] a_i + 1 modulo 2**N
module incN #(
  parameter int N = 8
) (
  input  logic [N-1:0] a_i,
  output logic [N-1:0] y_o
);

  assign y_o = a_i + N'(1);

endmodule

module pc_sequencer #(
  parameter int             N        = 8,
  parameter logic [N-1:0]   RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         stall,
  input  logic         br_taken,
  input  logic [N-1:0] br_target,
  input  logic         halt,
  input  logic         resume,
  output logic [N-1:0] pc,
  output logic         pc_valid,
  output logic         halted,
  output logic         wrap
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic [N-1:0] pc_q, pc_d;
  logic         pc_valid_q, pc_valid_d;
  logic         halted_q, halted_d;
  logic         wrap_q, wrap_d;
  logic [N-1:0] pc_inc;

  incN #(.N(N)) u_inc (
    .a_i (pc_q),
    .y_o (pc_inc)
  );

  // State and output registers. Reset lands in FLUSH so the first edge
  // after release behaves like the end of a redirect bubble: pc_valid rises
  // with pc still at RESET_PC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_FLUSH;
      pc_q       <= RESET_PC;
      pc_valid_q <= 1'b0;
      halted_q   <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_valid_q <= pc_valid_d;
      halted_q   <= halted_d;
      wrap_q     <= wrap_d;
    end
  end

  // Next-state logic. Priority inside a cycle: halt > br_taken > stall >
  // advance. wrap defaults low so it can only ever be a single-cycle pulse.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pc_valid_d = pc_valid_q;
    halted_d   = halted_q;
    wrap_d     = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (halt) begin
          state_d    = ST_HALTED;
          pc_valid_d = 1'b0;
          halted_d   = 1'b1;
        end else if (br_taken) begin
          // Taken even under stall so a redirect is never dropped.
          state_d    = ST_FLUSH;
          pc_d       = br_target;
          pc_valid_d = 1'b0;
        end else if (!stall) begin
          pc_d   = pc_inc;
          wrap_d = &pc_q;
        end
      end

      ST_FLUSH: begin
        // Bubble cycle: stall has no effect here.
        if (halt) begin
          state_d    = ST_HALTED;
          pc_valid_d = 1'b0;
          halted_d   = 1'b1;
        end else if (br_taken) begin
          // A back-to-back redirect restarts the bubble on the new target.
          state_d    = ST_FLUSH;
          pc_d       = br_target;
          pc_valid_d = 1'b0;
        end else begin
          state_d    = ST_RUN;
          pc_valid_d = 1'b1;
        end
      end

      ST_HALTED: begin
        // Only a clean resume (halt low) leaves; branches and stall are moot.
        if (resume && !halt) begin
          state_d    = ST_RUN;
          pc_valid_d = 1'b1;
          halted_d   = 1'b0;
        end
      end

      default: begin
        // Unused encoding: recover through a bubble.
        state_d    = ST_FLUSH;
        pc_valid_d = 1'b0;
        halted_d   = 1'b0;
      end
    endcase
  end

  assign pc       = pc_q;
  assign pc_valid = pc_valid_q;
  assign halted   = halted_q;
  assign wrap     = wrap_q;

endmodule
